// File: rtl/pc_pkg.sv
// Shared state type and default vectors for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VEC_DEF   = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC_DEF    = 32'h0000_0080;
  localparam int unsigned PC_INSTR_BYTES_DEF = 4;
  localparam int unsigned PC_RAS_DEPTH_DEF   = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating count.
// When full, a push overwrites the oldest entry; push+pop replaces the top in place.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign empty  = (cnt_q == '0);
  assign top    = mem_q[ptr_q];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && do_pop) begin
      wr_en = 1'b1;
    end else if (push) begin
      ptr_d  = ptr_q + PW'(1);
      wr_idx = ptr_q + PW'(1);
      wr_en  = 1'b1;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the entry array has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Sequenced next-PC generator (BOOT/RUN/HALT) at the head of fetch.
// Return-address stack is compiled in only when PC_UNIT_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(PC_TRAP_VEC_DEF),
  parameter int unsigned     INSTR_BYTES = PC_INSTR_BYTES_DEF,
  parameter int unsigned     RAS_DEPTH   = PC_RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] PC_Next,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] PC,
  output logic            pc_valid,
  output logic            misalign,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_seq;
  logic            bad_target;

  assign pc_seq     = pc_q + INC;
  assign bad_target = |(PC_Next & ALIGN_MASK);

`ifdef PC_UNIT_RAS_EN
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty_w;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .Reset     (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty_w)
  );

  assign ras_empty = ras_empty_w;
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;
  assign unused_ras_inputs = is_call ^ is_ret;
  assign ras_empty         = 1'b1;
`endif

  // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Halt is only taken when nothing of higher priority claims the cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!trap && !redirect && !stall && halt_req) state_d = HALT;
      HALT:    if (trap || resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
`ifdef PC_UNIT_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (trap) begin
          pc_d = TRAP_VEC;
        end else if (redirect && bad_target) begin
          pc_d       = TRAP_VEC;
          misalign_d = 1'b1;
        end else if (redirect) begin
          pc_d = PC_Next;
        end else if (stall || halt_req) begin
          pc_d = pc_q;
        end else begin
`ifdef PC_UNIT_RAS_EN
          ras_push = is_call;
          if (is_ret && !ras_empty_w) begin
            ras_pop = 1'b1;
            pc_d    = ras_top;
          end else begin
            pc_d = pc_seq;
          end
`else
          pc_d = pc_seq;
`endif
        end
      end
      HALT: begin
        if (trap) pc_d = TRAP_VEC;
      end
      default: pc_d = pc_q;
    endcase
    pc_valid_d = (state_d == RUN);
  end

  assign PC       = pc_q;
  assign pc_valid = pc_valid_q;
  assign misalign = misalign_q;

endmodule
